// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
// Multi-cycle Moore control FSM for the MIPS32 core. It sequences the shared datapath
// through fetch, decode, execute, memory and writeback, and stalls on mem_ready.
//
// Ports
//   clk, reset_pc           : rising-edge clock, asynchronous active-high reset
//   opcode, funct           : IR[31:26] / IR[5:0], latched in DECODE
//   zero                    : ALU zero flag (BRANCH)
//   mem_ready               : memory completes the current request this cycle
//   mem_req, mem_we, iord   : memory request, write enable, address select (0 PC, 1 ALUOut)
//   ir_write, pc_en, pc_src : IR load, PC load, PC source (00 ALU, 01 ALUOut, 10 jump)
//   reg_write, reg_dst      : register file write enable, dest select (0 rt, 1 rd)
//   mem_to_reg              : writeback select (0 ALUOut, 1 MDR)
//   alu_src_a, alu_src_b    : ALU operand selects
//   alu_ctrl                : ALU operation
//   instr_done              : pulse on the last cycle of each instruction
//   illegal_op              : sticky trap flag (only with CTRL_ILLEGAL_TRAP_EN)
//   state                   : current state, for debug
//
// Configuration macro: CTRL_ILLEGAL_TRAP_EN -- illegal instructions park the FSM in TRAP
// until reset. Without it they retire as a NOP from DECODE.

module mips_multicycle_ctrl #(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset_pc,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               iord,
  output logic               ir_write,
  output logic               pc_en,
  output logic [1:0]         pc_src,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [3:0]         alu_ctrl,
  output logic               instr_done,
`ifdef CTRL_ILLEGAL_TRAP_EN
  output logic               illegal_op,
`endif
  output logic [STATE_W-1:0] state
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExecR  = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
    StAddiEx = 4'd9,
    StJump   = 4'd10,
    StTrap   = 4'd11
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;

  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnSlt = 6'b101010;

  localparam logic [3:0] AluAnd = 4'b0000;
  localparam logic [3:0] AluOr  = 4'b0001;
  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSub = 4'b0110;
  localparam logic [3:0] AluSlt = 4'b0111;

  state_e     r_state;
  logic [5:0] r_opcode;
  logic [5:0] r_funct;

  logic w_funct_ok;
  logic w_legal;

  // Legality is judged on the live IR fields in DECODE, funct only matters for R-type.
  assign w_funct_ok = funct inside {FnAnd, FnOr, FnAdd, FnSub, FnSlt};
  assign w_legal    = ((opcode == OpRtype) && w_funct_ok) ||
                      (opcode inside {OpLw, OpSw, OpBeq, OpJ, OpAddi});

  always_ff @(posedge clk or posedge reset_pc) begin
    if (reset_pc) begin
      r_state  <= StFetch;
      r_opcode <= 6'd0;
      r_funct  <= 6'd0;
    end else begin
      unique case (r_state)
        StFetch:  if (mem_ready) r_state <= StDecode;
        StDecode: begin
          r_opcode <= opcode;
          r_funct  <= funct;
          if (!w_legal) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            r_state <= StTrap;
`else
            r_state <= StFetch;
`endif
          end else begin
            unique case (opcode)
              OpRtype: r_state <= StExecR;
              OpLw,
              OpSw:    r_state <= StMemAdr;
              OpBeq:   r_state <= StBranch;
              OpJ:     r_state <= StJump;
              default: r_state <= StAddiEx;
            endcase
          end
        end
        StMemAdr: r_state <= (r_opcode == OpLw) ? StMemRd : StMemWr;
        StMemRd:  if (mem_ready) r_state <= StMemWb;
        StMemWr:  if (mem_ready) r_state <= StFetch;
        StExecR,
        StAddiEx: r_state <= StAluWb;
        StTrap:   r_state <= StTrap;
        default:  r_state <= StFetch;
      endcase
    end
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_en      = 1'b0;
    pc_src     = 2'b00;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_ctrl   = AluAdd;
    instr_done = 1'b0;
    // Reset masks everything so no partial strobe leaks out while the state is forced.
    if (!reset_pc) begin
      unique case (r_state)
        StFetch: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write  = 1'b1;
            pc_en     = 1'b1;
            alu_src_b = 2'b01;
          end
        end
        StDecode: begin
          alu_src_b = 2'b11;
`ifndef CTRL_ILLEGAL_TRAP_EN
          instr_done = !w_legal;
`endif
        end
        StMemAdr,
        StAddiEx: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        StMemRd: begin
          mem_req = 1'b1;
          iord    = 1'b1;
        end
        StMemWb: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        StMemWr: begin
          mem_req    = 1'b1;
          mem_we     = 1'b1;
          iord       = 1'b1;
          instr_done = mem_ready;
        end
        StExecR: begin
          alu_src_a = 1'b1;
          unique case (r_funct)
            FnAnd:   alu_ctrl = AluAnd;
            FnOr:    alu_ctrl = AluOr;
            FnSub:   alu_ctrl = AluSub;
            FnSlt:   alu_ctrl = AluSlt;
            default: alu_ctrl = AluAdd;
          endcase
        end
        StAluWb: begin
          reg_write  = 1'b1;
          reg_dst    = (r_opcode != OpAddi);
          instr_done = 1'b1;
        end
        StBranch: begin
          alu_src_a  = 1'b1;
          alu_ctrl   = AluSub;
          pc_src     = 2'b01;
          pc_en      = zero;
          instr_done = 1'b1;
        end
        StJump: begin
          pc_en      = 1'b1;
          pc_src     = 2'b10;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  // TRAP only exits through reset, so the state itself is the sticky flag.
  assign illegal_op = (r_state == StTrap);
`endif

  assign state = STATE_W'(r_state);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: the stimulus process walks instructions
// cycle by cycle, pushes the expected output vector for each cycle, and a negedge
// monitor pops and compares against the DUT.

module tb_mips_multicycle_ctrl;

`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] st;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_ctrl;
    logic       instr_done;
    logic       illegal_op;
  } out_t;

  typedef struct {
    out_t  e;
    string tag;
  } item_t;

  logic       clk = 1'b0;
  logic       reset_pc;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       mem_req, mem_we, iord, ir_write, pc_en, reg_write, reg_dst, mem_to_reg;
  logic       alu_src_a, instr_done, ill_w;
  logic [1:0] pc_src, alu_src_b;
  logic [3:0] alu_ctrl, state;

  item_t sb_q[$];
  item_t mon_it;
  out_t  act;
  int    n_cmp = 0;
  int    n_bad = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.STATE_W(4)) dut (
    .clk        (clk),
    .reset_pc   (reset_pc),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .iord       (iord),
    .ir_write   (ir_write),
    .pc_en      (pc_en),
    .pc_src     (pc_src),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_ctrl   (alu_ctrl),
    .instr_done (instr_done),
`ifdef CTRL_ILLEGAL_TRAP_EN
    .illegal_op (ill_w),
`endif
    .state      (state)
  );

`ifndef CTRL_ILLEGAL_TRAP_EN
  assign ill_w = 1'b0;
`endif

  // Monitor: one expected vector per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_it = sb_q.pop_front();
      act = '{st: state, mem_req: mem_req, mem_we: mem_we, iord: iord, ir_write: ir_write,
              pc_en: pc_en, pc_src: pc_src, reg_write: reg_write, reg_dst: reg_dst,
              mem_to_reg: mem_to_reg, alu_src_a: alu_src_a, alu_src_b: alu_src_b,
              alu_ctrl: alu_ctrl, instr_done: instr_done, illegal_op: ill_w};
      n_cmp++;
      if (act !== mon_it.e) begin
        n_bad++;
        $display("FAIL %s @%0t: got %h (state %0d) expected %h (state %0d)", mon_it.tag,
                 $time, act, act.st, mon_it.e, mon_it.e.st);
      end
    end
  end

  function automatic out_t base(input logic [3:0] st);
    out_t e;
    e = '0;
    e.st = st;
    e.alu_ctrl = 4'b0010;
    return e;
  endfunction

  function automatic logic [3:0] alu_of(input logic [5:0] fn);
    case (fn)
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b100010: return 4'b0110;
      6'b101010: return 4'b0111;
      default:   return 4'b0010;
    endcase
  endfunction

  function automatic bit funct_ok(input logic [5:0] fn);
    return fn inside {6'b100100, 6'b100101, 6'b100000, 6'b100010, 6'b101010};
  endfunction

  function automatic bit legal(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'b000000) return funct_ok(fn);
    return op inside {6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
  endfunction

  task automatic step(input out_t e, input string tag);
    item_t it;
    it.e = e;
    it.tag = tag;
    sb_q.push_back(it);
    @(posedge clk);
    #1;
  endtask

  // Inputs the current state must ignore get random values.
  task automatic noise();
    mem_ready = 1'($urandom);
    zero      = 1'($urandom);
  endtask

  task automatic do_reset(input int n);
    reset_pc = 1'b1;
    for (int i = 0; i < n; i++) begin
      noise();
      opcode = 6'($urandom);
      step(base(4'd0), "reset");
    end
    reset_pc = 1'b0;
  endtask

  // Walks one instruction through the control unit. wf/wm are memory wait cycles in the
  // fetch and data phases; abort_wr pulses reset during a stalled store.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int wf, input int wm, input bit abort_wr);
    out_t e;
    opcode = op;
    funct  = fn;
    for (int i = 0; i < wf; i++) begin
      mem_ready = 1'b0;
      zero = 1'($urandom);
      e = base(4'd0);
      e.mem_req = 1'b1;
      step(e, "fetch_wait");
    end
    mem_ready = 1'b1;
    e = base(4'd0);
    e.mem_req = 1'b1;
    e.ir_write = 1'b1;
    e.pc_en = 1'b1;
    e.alu_src_b = 2'b01;
    step(e, "fetch");

    noise();
    e = base(4'd1);
    e.alu_src_b = 2'b11;
    if (!legal(op, fn)) begin
      if (TrapEn) begin
        step(e, "decode_illegal");
        for (int i = 0; i < 3 + int'($urandom_range(0, 3)); i++) begin
          noise();
          opcode = 6'($urandom);
          e = base(4'd11);
          e.illegal_op = 1'b1;
          step(e, "trap_hold");
        end
        do_reset(1 + int'($urandom_range(0, 2)));
      end else begin
        e.instr_done = 1'b1;
        step(e, "decode_nop");
      end
      return;
    end
    step(e, "decode");
    // The IR fields are latched; later states must not follow the live inputs.
    opcode = 6'($urandom);
    funct  = 6'($urandom);

    case (op)
      6'b000000, 6'b001000: begin
        noise();
        if (op == 6'b000000) begin
          e = base(4'd6);
          e.alu_ctrl = alu_of(fn);
        end else begin
          e = base(4'd9);
          e.alu_src_b = 2'b10;
        end
        e.alu_src_a = 1'b1;
        step(e, "execute");
        noise();
        e = base(4'd7);
        e.reg_write = 1'b1;
        e.reg_dst = (op == 6'b000000);
        e.instr_done = 1'b1;
        step(e, "alu_wb");
      end
      6'b100011, 6'b101011: begin
        noise();
        e = base(4'd2);
        e.alu_src_a = 1'b1;
        e.alu_src_b = 2'b10;
        step(e, "mem_addr");
        for (int i = 0; i <= wm; i++) begin
          mem_ready = (i == wm);
          zero = 1'($urandom);
          e = base((op == 6'b100011) ? 4'd3 : 4'd5);
          e.mem_req = 1'b1;
          e.iord = 1'b1;
          e.mem_we = (op == 6'b101011);
          e.instr_done = (op == 6'b101011) && mem_ready;
          if (abort_wr && op == 6'b101011) begin
            mem_ready = 1'b0;
            e.instr_done = 1'b0;
            step(e, "mem_wr_stall");
            do_reset(1);
            return;
          end
          step(e, mem_ready ? "mem_access" : "mem_wait");
        end
        if (op == 6'b100011) begin
          noise();
          e = base(4'd4);
          e.reg_write = 1'b1;
          e.mem_to_reg = 1'b1;
          e.instr_done = 1'b1;
          step(e, "mem_wb");
        end
      end
      6'b000100: begin
        mem_ready = 1'($urandom);
        zero = z;
        e = base(4'd8);
        e.alu_src_a = 1'b1;
        e.alu_ctrl = 4'b0110;
        e.pc_src = 2'b01;
        e.pc_en = z;
        e.instr_done = 1'b1;
        step(e, z ? "branch_taken" : "branch_not_taken");
      end
      default: begin
        noise();
        e = base(4'd10);
        e.pc_en = 1'b1;
        e.pc_src = 2'b10;
        e.instr_done = 1'b1;
        step(e, "jump");
      end
    endcase
  endtask

  initial begin
    logic [5:0] fns [5];
    logic [5:0] op, fn;
    fns = '{6'b100100, 6'b100101, 6'b100000, 6'b100010, 6'b101010};
    reset_pc  = 1'b1;
    opcode    = 6'd0;
    funct     = 6'd0;
    zero      = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;

    // Directed sequence
    do_reset(3);
    mem_ready = 1'b1;
    run_instr(6'b000000, 6'b100010, 1'b0, 0, 0, 1'b0);   // sub
    run_instr(6'b100011, 6'd0, 1'b0, 0, 2, 1'b0);        // lw, 2 wait cycles
    run_instr(6'b000100, 6'd0, 1'b1, 0, 0, 1'b0);        // beq taken
    run_instr(6'b000100, 6'd0, 1'b0, 0, 0, 1'b0);        // beq not taken
    run_instr(6'b101011, 6'd0, 1'b0, 1, 1, 1'b0);        // sw with waits
    run_instr(6'b000010, 6'd0, 1'b0, 0, 0, 1'b0);        // j
    run_instr(6'b001000, 6'd0, 1'b0, 0, 0, 1'b0);        // addi
    run_instr(6'b111111, 6'd0, 1'b0, 0, 0, 1'b0);        // illegal opcode
    run_instr(6'b000000, 6'b111111, 1'b0, 0, 0, 1'b0);   // illegal funct
    run_instr(6'b101011, 6'd0, 1'b0, 0, 0, 1'b1);        // sw aborted by reset
    run_instr(6'b000000, 6'b100100, 1'b0, 0, 0, 1'b0);   // and after restart

    // Randomized mix
    for (int n = 0; n < 300; n++) begin
      fn = 6'($urandom);
      case ($urandom_range(0, 9))
        0, 1:    begin op = 6'b000000; fn = fns[$urandom_range(0, 4)]; end
        2:       op = 6'b100011;
        3:       op = 6'b101011;
        4:       op = 6'b000100;
        5:       op = 6'b000010;
        6:       op = 6'b001000;
        7:       begin op = 6'b000000; while (funct_ok(fn)) fn = 6'($urandom); end
        8:       begin op = 6'($urandom); while (legal(op, 6'd0)) op = 6'($urandom); end
        default: begin op = 6'b101011; end
      endcase
      run_instr(op, fn, 1'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                ($urandom_range(0, 15) == 0));
    end

    @(negedge clk);
    #1;
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
